// File: rtl/skewed_operand_buffer.sv
// skewed_operand_buffer: LANES x DEPTH operand store streaming a window
// of each lane into a systolic array, lane i delayed by i cycles.
// Ports: clk, rst_n (sync, active-low); wr_en/wr_lane/wr_addr/wr_data
// element write; start/base/len stream request; busy, done, out_valid,
// lane_valid, data_out (lane i at [i*DATA_WIDTH +: DATA_WIDTH]).
// Option: define SKEWED_OPBUF_TRANSPOSE_EN to add the transpose input
// (column-major reads, needs LANES == DEPTH).
module skewed_operand_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int LANES      = 4,
  parameter int DEPTH      = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wr_en,
  input  logic [$clog2(LANES)-1:0]      wr_lane,
  input  logic [$clog2(DEPTH)-1:0]      wr_addr,
  input  logic [DATA_WIDTH-1:0]         wr_data,
  input  logic                          start,
  input  logic [$clog2(DEPTH)-1:0]      base,
  input  logic [$clog2(DEPTH):0]        len,
`ifdef SKEWED_OPBUF_TRANSPOSE_EN
  input  logic                          transpose,
`endif
  output logic                          busy,
  output logic                          done,
  output logic                          out_valid,
  output logic [LANES-1:0]              lane_valid,
  output logic [LANES*DATA_WIDTH-1:0]   data_out
);

  localparam int LANE_W = $clog2(LANES);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int S_W    = $clog2(DEPTH + LANES) + 1;

`ifdef SKEWED_OPBUF_TRANSPOSE_EN
  if (LANES != DEPTH) begin : g_tr_chk
    $error("transpose needs LANES == DEPTH");
  end
`endif

  typedef enum logic {IDLE, STREAM} state_e;

  state_e                                   state_q, state_d;
  logic [S_W-1:0]                           step_q, step_d;
  logic [ADDR_W-1:0]                        base_q, base_d;
  logic [ADDR_W:0]                          len_q, len_d;
  logic                                     done_q, done_d;
  logic [LANES-1:0]                         lv_q, lv_d;
  logic [LANES*DATA_WIDTH-1:0]              data_q, data_d;
  logic [LANES-1:0][DEPTH-1:0][DATA_WIDTH-1:0] mem_q, mem_d;
`ifdef SKEWED_OPBUF_TRANSPOSE_EN
  logic                                     tr_q, tr_d;
`endif

  logic [S_W-1:0]    last_step;
  logic [ADDR_W:0]   len_clamp;
  int                k;
  logic [ADDR_W-1:0] addr;

  assign last_step = S_W'(len_q) + S_W'(LANES - 2);
  assign len_clamp = (len > (ADDR_W+1)'(DEPTH)) ?
                     (ADDR_W+1)'(DEPTH) : len;

  always_comb begin
    mem_d = mem_q;
    if (wr_en && (32'(wr_lane) < LANES))
      mem_d[wr_lane][wr_addr] = wr_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      step_q  <= '0;
      base_q  <= '0;
      len_q   <= '0;
      done_q  <= 1'b0;
      lv_q    <= '0;
      data_q  <= '0;
      mem_q   <= '0;
`ifdef SKEWED_OPBUF_TRANSPOSE_EN
      tr_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      base_q  <= base_d;
      len_q   <= len_d;
      done_q  <= done_d;
      lv_q    <= lv_d;
      data_q  <= data_d;
      mem_q   <= mem_d;
`ifdef SKEWED_OPBUF_TRANSPOSE_EN
      tr_q    <= tr_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    base_d  = base_q;
    len_d   = len_q;
`ifdef SKEWED_OPBUF_TRANSPOSE_EN
    tr_d    = tr_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          base_d = base;
          len_d  = len_clamp;
          step_d = '0;
`ifdef SKEWED_OPBUF_TRANSPOSE_EN
          tr_d   = transpose;
`endif
          if (len != '0) state_d = STREAM;
        end
      end
      STREAM: begin
        if (step_q == last_step) state_d = IDLE;
        else step_d = step_q + 1'b1;
      end
    endcase
  end

  // Outputs are registered, so the step being entered is computed from
  // the next-state values; mem_q gives read-before-write on collisions.
  always_comb begin
    lv_d   = '0;
    data_d = '0;
    k      = 0;
    addr   = '0;
    done_d = ((state_q == STREAM) && (state_d == IDLE)) ||
             ((state_q == IDLE) && start && (len == '0));
    if (state_d == STREAM) begin
      for (int i = 0; i < LANES; i++) begin
        k = int'(step_d) - i;
        if ((k >= 0) && (k < int'(len_d))) begin
          lv_d[i] = 1'b1;
          addr = base_d + ADDR_W'(k);
          data_d[i*DATA_WIDTH +: DATA_WIDTH] = mem_q[i][addr];
`ifdef SKEWED_OPBUF_TRANSPOSE_EN
          if (tr_d)
            data_d[i*DATA_WIDTH +: DATA_WIDTH] =
              mem_q[LANE_W'(addr)][ADDR_W'(i)];
`endif
        end
      end
    end
  end

  assign busy       = (state_q == STREAM);
  assign out_valid  = (state_q == STREAM);
  assign done       = done_q;
  assign lane_valid = lv_q;
  assign data_out   = data_q;

endmodule

// File: doc/skewed_operand_buffer.md
Name: skewed_operand_buffer

Overview:
Parametrised successor to the 4x4 operand memory. Holds a LANES x DEPTH array of DATA_WIDTH-bit operands and streams a programmable window of each lane into the systolic array. Lane i is delayed by i cycles (diagonal skew), so the sequencer needs no external skew registers. Single element-write port on the loader side; registered, skewed streaming output on the array side.

Parameters:
DATA_WIDTH, 8, bits per operand element
LANES, 4, number of lanes/array rows fed; >=2
DEPTH, 8, elements per lane; power of 2, >=2
LANE_W, $clog2(LANES), lane index width (derived, localparam)
ADDR_W, $clog2(DEPTH), element address width (derived, localparam)

Ports:
clk  input  1  clock; all logic on rising edge
rst_n  input  1  synchronous, active-low reset
wr_en  input  1  write strobe
wr_lane  input  LANE_W  lane to write
wr_addr  input  ADDR_W  element to write
wr_data  input  DATA_WIDTH  write data
start  input  1  stream request; sampled only in IDLE
base  input  ADDR_W  first element of the window; captured on accept
len  input  ADDR_W+1  window length in elements; captured on accept
busy  output  1  stream in progress
done  output  1  one-cycle pulse at end of stream
out_valid  output  1  data_out holds a stream step
lane_valid  output  LANES  per-lane element-valid
data_out  output  LANES*DATA_WIDTH  lane i at bits [i*DATA_WIDTH +: DATA_WIDTH]

Behaviour:
- One clock, clk. Reset is synchronous and active-low on rst_n. While rst_n=0 at a clk edge: all mem cells clear to 0; state goes to IDLE; busy, done, out_valid, lane_valid and data_out clear to 0. Reset asserted mid-stream aborts the stream with no done pulse.
- Write: on an edge with wr_en=1, mem[wr_lane][wr_addr] <= wr_data. Writes are accepted in any state. wr_lane >= LANES is ignored.
- FSM states: IDLE and STREAM.
- IDLE to STREAM: on an edge E0 with start=1, capture base and L=min(len,DEPTH). Clear step counter s to 0.
- len=0: stay in IDLE and pulse done after E0. No valid output is produced.
- Step timing: data_out is registered. After edge E0+s, for s = 0 .. L+LANES-2, outputs reflect step s.
  - out_valid=1 and busy=1.
  - For each lane i, k = s-i. If 0 <= k < L: lane_valid[i]=1 and lane i data = mem[i][(base+k) mod DEPTH]. Otherwise lane_valid[i]=0 and lane i data = 0.
- Address wrap: address arithmetic is modulo DEPTH (ADDR_W-bit natural wrap).
- Stream end: after edge E0+L+LANES-1, the block returns to IDLE. out_valid=0, lane_valid=0, data_out=0, busy=0, and done=1 for exactly one cycle.
- start while busy: ignored. A start on the edge where done is asserted (state already IDLE) is accepted; back-to-back streams have no gap beyond that cycle.
- Read/write collision: a read and a write to the same cell on the same edge return the old data (read-before-write). The new data is visible from the next edge.
- Total latency: L+LANES-1 valid cycles, plus 1 done cycle.

Optional Feature:
Macro SKEWED_OPBUF_TRANSPOSE_EN.
- Defined: adds input port transpose (1 bit), captured on accept. When the captured value is 1, lane i element k = mem[(base+k) mod DEPTH][i]. Elaboration requires LANES==DEPTH ($error otherwise). Skew and valid rules are unchanged.
- Undefined: no transpose port; row-major reads only.

Test Plan:
All scenarios use LANES=4, DEPTH=8, DATA_WIDTH=8, with mem[i][k] = 16*i+k preloaded.
- Reset: hold rst_n=0 for 2 edges after arbitrary writes -> all outputs 0, busy=0, and a subsequent stream base=0 len=1 returns lane0=0x00.
- Skew: start base=0 len=3 -> out_valid for 6 cycles. Step0: lane_valid=0001, lane0=0x00. Step2: lane_valid=0111 with 0x02/0x11/0x20. Step5: lane_valid=1000, lane3=0x32. done pulses after edge E0+6.
- Wrap and clamp: base=6 len=4 -> lane0 sequence 0x06,0x07,0x00,0x01. Separately, len=12 clamps to 8 -> 11 valid cycles.
- Collision and ignore: during a stream, write mem[1][1]=0xAA on the edge lane1 reads k=1 -> that step shows 0x11. Pulse start mid-stream -> no restart. Write with wr_lane=4 is impossible at LANE_W=2; use len=0 instead -> done only, out_valid never 1.
- Reset mid-stream: drop rst_n at step 3 -> the next cycle has all outputs 0, no done, and mem is cleared.
- Transpose (SKEWED_OPBUF_TRANSPOSE_EN, DEPTH=4): transpose=1, base=0, len=4 -> lane2 sequence 0x02,0x12,0x22,0x32.
